// File: rtl/mips_multicycle_seq_if.sv
// Memory handshake bundle between the multicycle sequencer and instruction/data memory.
//   imem_req   : sequencer -> imem, fetch request (held until imem_ready)
//   imem_ready : imem -> sequencer, fetch data valid this cycle
//   dmem_req   : sequencer -> dmem, data access request (held until dmem_ready)
//   dmem_we    : sequencer -> dmem, 1 = store, valid while dmem_req=1
//   dmem_ready : dmem -> sequencer, data access complete this cycle
interface mips_multicycle_seq_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/mips_multicycle_seq.sv
// Multicycle sequencer for the MIPS datapath: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, emits the IR/ALU/regfile/PC strobes, runs the memory
// handshakes, traps on illegal opcodes or memory timeouts and counts retirements.
// ALU/mux selects still come from the combinational decoder beside this block.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   i_run              execute enable, sampled at instruction boundaries
//   i_opcode, i_funct  IR[31:26] and IR[5:0], valid from DECODE onward
//   mem                memory handshake bundle (master side)
//   o_ir_we            IR load pulse (fetch ready cycle)
//   o_alu_en           ALU register enable (EXEC)
//   o_reg_we           register-file write pulse (WB)
//   o_pc_we, o_pc_sel  PC update pulse and source (0 PC+4, 1 jump, 2 jr)
//   o_busy             1 in any state except IDLE/TRAP
//   o_trap, o_bus_err  sticky trap flag, and timeout cause flag
//   o_instr_count      retired instruction count, wraps
//   o_state            IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=7
module mips_multicycle_seq #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_run,
  input  logic [5:0]           i_opcode,
  input  logic [5:0]           i_funct,
  mips_multicycle_seq_if.master mem,
  output logic                 o_ir_we,
  output logic                 o_alu_en,
  output logic                 o_reg_we,
  output logic                 o_pc_we,
  output logic [1:0]           o_pc_sel,
  output logic                 o_busy,
  output logic                 o_trap,
  output logic                 o_bus_err,
  output logic [CNT_W-1:0]     o_instr_count,
  output logic [2:0]           o_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  // Wait counter saturates at TIMEOUT, so it only needs to hold that value.
  localparam int unsigned WAIT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_trap;
  logic              r_bus_err;
  logic [CNT_W-1:0]  r_instr_count;

  logic w_ir_we, w_alu_en, w_reg_we, w_pc_we;
  logic [1:0] w_pc_sel;
  logic w_imem_req, w_dmem_req, w_dmem_we;
  logic w_retire, w_timeout_err;

  // Instruction class decode
  logic w_is_r, w_r_alu, w_jr, w_imm, w_lw, w_sw, w_j, w_legal, w_is_jump, w_is_mem;
  always_comb begin
    w_is_r    = (i_opcode == 6'h00);
    w_r_alu   = w_is_r && (i_funct inside {6'h20, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A});
    w_jr      = w_is_r && (i_funct == 6'h08);
    w_imm     = i_opcode inside {6'h08, 6'h0A, 6'h0C, 6'h0D};
    w_lw      = (i_opcode == 6'h23);
    w_sw      = (i_opcode == 6'h2B);
    w_j       = (i_opcode == 6'h02);
    w_is_jump = w_j || w_jr;
    w_is_mem  = w_lw || w_sw;
    w_legal   = w_r_alu || w_jr || w_imm || w_lw || w_sw || w_j;
  end

  // The count has hit the limit with no ready this cycle (a ready in this cycle wins).
  logic w_wait_expired;
  assign w_wait_expired = (TIMEOUT != 0) && (r_wait == WAIT_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and strobes
  always_comb begin
    w_state_next  = r_state;
    w_ir_we       = 1'b0;
    w_alu_en      = 1'b0;
    w_reg_we      = 1'b0;
    w_pc_we       = 1'b0;
    w_pc_sel      = 2'd0;
    w_imem_req    = 1'b0;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    w_retire      = 1'b0;
    w_timeout_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (mem.imem_ready) begin
          w_ir_we      = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_wait_expired) begin
          w_timeout_err = 1'b1;
          w_state_next  = S_TRAP;
        end
      end
      S_DECODE: begin
        w_state_next = w_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        w_alu_en = 1'b1;
        if (w_is_jump) begin
          w_pc_we  = 1'b1;
          w_pc_sel = w_j ? 2'd1 : 2'd2;
          w_retire = 1'b1;
        end else if (w_is_mem) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_sw;
        if (mem.dmem_ready) begin
          if (w_sw) begin
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
          end else begin
            w_state_next = S_WB;
          end
        end else if (w_wait_expired) begin
          w_timeout_err = 1'b1;
          w_state_next  = S_TRAP;
        end
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_pc_we  = 1'b1;
        w_retire = 1'b1;
      end
      S_TRAP: begin
        w_state_next = S_TRAP;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // Retirement is an instruction boundary: run is sampled here.
    if (w_retire) w_state_next = i_run ? S_FETCH : S_IDLE;
  end

  // Wait counter: clears on any state change, counts stalled memory cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait <= '0;
    end else if (w_state_next != r_state) begin
      r_wait <= '0;
    end else if (((r_state == S_FETCH) && !mem.imem_ready) ||
                 ((r_state == S_MEM) && !mem.dmem_ready)) begin
      if (r_wait != WAIT_MAX) r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Sticky trap flags and retirement counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_trap        <= 1'b0;
      r_bus_err     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      if ((w_state_next == S_TRAP) && (r_state != S_TRAP)) r_trap <= 1'b1;
      if (w_timeout_err) r_bus_err <= 1'b1;
      if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign mem.imem_req  = w_imem_req;
  assign mem.dmem_req  = w_dmem_req;
  assign mem.dmem_we   = w_dmem_we;
  assign o_ir_we       = w_ir_we;
  assign o_alu_en      = w_alu_en;
  assign o_reg_we      = w_reg_we;
  assign o_pc_we       = w_pc_we;
  assign o_pc_sel      = w_pc_sel;
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_TRAP);
  assign o_trap        = r_trap;
  assign o_bus_err     = r_bus_err;
  assign o_instr_count = r_instr_count;
  assign o_state       = r_state;

endmodule

// File: tb/tb_mips_multicycle_seq.sv
// Scoreboard bench for mips_multicycle_seq: the stimulus pushes the expected
// retire/trap record for every instruction it issues, and an independent monitor
// pops and compares whenever the sequencer retires (pc_we) or enters TRAP.
module tb_mips_multicycle_seq;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned TMO   = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_MEM   = 3'd4;
  localparam logic [2:0] ST_WB    = 3'd5;
  localparam logic [2:0] ST_TRAP  = 3'd7;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             ir_we, alu_en, reg_we, pc_we, busy, trap, bus_err;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] instr_count;
  logic [2:0]       state;

  mips_multicycle_seq_if mem_bus ();

  mips_multicycle_seq #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_run         (run),
    .i_opcode      (opcode),
    .i_funct       (funct),
    .mem           (mem_bus),
    .o_ir_we       (ir_we),
    .o_alu_en      (alu_en),
    .o_reg_we      (reg_we),
    .o_pc_we       (pc_we),
    .o_pc_sel      (pc_sel),
    .o_busy        (busy),
    .o_trap        (trap),
    .o_bus_err     (bus_err),
    .o_instr_count (instr_count),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          kind;   // 0 = retire, 1 = trap
    logic [1:0]  psel;
    logic        rwe;
    int          lat;    // cycles from FETCH entry to retire, inclusive
    int          dreq;   // cycles with dmem_req high
    logic        dwe;
    logic        berr;
    logic [14:0] path;   // visited states, one octal digit each
    logic [31:0] cnt;    // instr_count before this retirement
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Monitor: per-instruction trace, strobe sanity every cycle, scoreboard pops on events.
  logic [2:0]  m_prev_st   = 3'd0;
  logic        m_prev_trap = 1'b0;
  logic [14:0] m_path      = '0;
  int          m_lat       = 0;
  int          m_dreq      = 0;
  logic        m_dwe       = 1'b0;

  always begin : monitor
    logic [2:0] st;
    logic       bad;
    exp_t       e;
    @(negedge clk);
    #1;
    st = state;
    if (st == ST_FETCH && m_prev_st != ST_FETCH) begin
      m_path = 15'o1; m_lat = 1; m_dreq = 0; m_dwe = 1'b0;
    end else begin
      m_lat++;
      if (st != m_prev_st) m_path = {m_path[11:0], st};
    end
    if (mem_bus.dmem_req) begin
      m_dreq++;
      m_dwe = m_dwe | mem_bus.dmem_we;
    end
    bad = (ir_we && st != ST_FETCH) ||
          (reg_we && !(st == ST_WB && pc_we)) ||
          (st == ST_WB && !(reg_we && pc_we)) ||
          (pc_we && !(st inside {ST_EXEC, ST_MEM, ST_WB})) ||
          (alu_en != (st == ST_EXEC)) ||
          (mem_bus.imem_req != (st == ST_FETCH)) ||
          (mem_bus.dmem_req != (st == ST_MEM)) ||
          (busy != (st inside {[ST_FETCH:ST_WB]})) ||
          (trap != (st == ST_TRAP));
    chk("strobes", {63'd0, bad}, 64'd0);
    if (pc_we) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_retire: state=%0d, no instruction pending", st);
      end else begin
        e = exp_q.pop_front();
        $display("retire id=%0d", e.id);
        chk("event_kind", 64'(0), 64'(e.kind));
        chk("pc_sel", 64'(pc_sel), 64'(e.psel));
        chk("reg_we", 64'(reg_we), 64'(e.rwe));
        chk("latency", 64'(m_lat), 64'(e.lat));
        chk("dmem_req_cycles", 64'(m_dreq), 64'(e.dreq));
        chk("dmem_we", 64'(m_dwe), 64'(e.dwe));
        chk("state_path", 64'(m_path), 64'(e.path));
        chk("count_before_retire", 64'(instr_count), 64'(e.cnt));
      end
    end
    if (trap && !m_prev_trap) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_trap: bus_err=%0d, no instruction pending", bus_err);
      end else begin
        e = exp_q.pop_front();
        $display("trap id=%0d", e.id);
        chk("event_kind", 64'(1), 64'(e.kind));
        chk("bus_err", 64'(bus_err), 64'(e.berr));
        chk("state_path", 64'(m_path), 64'(e.path));
      end
    end
    m_prev_st   = st;
    m_prev_trap = trap;
  end

  // Push the expected record, then play memory with the given ready delays until the
  // instruction reaches a boundary (FETCH/IDLE after leaving FETCH, or TRAP).
  task automatic issue(input int id, input logic [5:0] op, input logic [5:0] fn,
                       input int idly, input int ddly, input bit drop_run,
                       input int kind, input logic [1:0] psel, input logic rwe,
                       input int lat, input int dreq, input logic dwe,
                       input logic berr, input logic [14:0] path);
    exp_t       e;
    int         ic;
    int         dc;
    bit         left;
    bit         done;
    logic [2:0] st;
    e.id = id; e.kind = kind; e.psel = psel; e.rwe = rwe; e.lat = lat;
    e.dreq = dreq; e.dwe = dwe; e.berr = berr; e.path = path; e.cnt = m_cnt;
    exp_q.push_back(e);
    if (kind == 0) m_cnt++;
    opcode = op;
    funct  = fn;
    ic = 0; dc = 0; left = 1'b0; done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      st = state;
      if (st == ST_TRAP || (left && (st == ST_IDLE || st == ST_FETCH))) begin
        done = 1'b1;
      end else begin
        if (st inside {[3'd2:3'd5]}) left = 1'b1;
        mem_bus.imem_ready = (st == ST_FETCH) && (ic == idly);
        mem_bus.dmem_ready = (st == ST_MEM) && (dc == ddly);
        if (st == ST_FETCH) ic++;
        if (st == ST_MEM) dc++;
        if (drop_run && st == ST_MEM) run = 1'b0;
        @(negedge clk);
      end
    end
    mem_bus.imem_ready = 1'b0;
    mem_bus.dmem_ready = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL issue_bound id=%0d: state=%0d, expected a boundary within 80 cycles", id, state);
    end
  endtask

  task automatic do_reset();
    run   = 1'b0;
    reset = 1'b1;
    mem_bus.imem_ready = 1'b0;
    mem_bus.dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_cnt = 0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = 6'h00; funct = 6'h20;
    mem_bus.imem_ready = 1'b0;
    mem_bus.dmem_ready = 1'b0;
    do_reset();
    chk("reset_state", 64'(state), 64'(ST_IDLE));
    chk("reset_count", 64'(instr_count), 64'd0);
    chk("reset_trap", 64'(trap), 64'd0);
    chk("reset_bus_err", 64'(bus_err), 64'd0);
    chk("reset_pc_sel", 64'(pc_sel), 64'd0);
    chk("reset_imem_req", 64'(mem_bus.imem_req), 64'd0);

    // Readies while nothing is requested must not move the sequencer.
    mem_bus.imem_ready = 1'b1;
    mem_bus.dmem_ready = 1'b1;
    wait_cycles(3);
    chk("idle_hold_state", 64'(state), 64'(ST_IDLE));
    chk("idle_hold_count", 64'(instr_count), 64'd0);
    mem_bus.imem_ready = 1'b0;
    mem_bus.dmem_ready = 1'b0;

    // Back-to-back program with run held high.
    run = 1'b1;
    //    id op     fn    idly ddly drop kind psel rwe lat dreq dwe berr path
    issue(1, 6'h00, 6'h20, 0, 0, 0, 0, 2'd0, 1, 4,  0, 0, 0, 15'o1235);   // add
    issue(2, 6'h23, 6'h00, 0, 3, 0, 0, 2'd0, 1, 8,  4, 0, 0, 15'o12345);  // lw, 3 waits
    issue(3, 6'h2B, 6'h00, 0, 0, 0, 0, 2'd0, 0, 4,  1, 1, 0, 15'o1234);   // sw
    issue(4, 6'h02, 6'h00, 0, 0, 0, 0, 2'd1, 0, 3,  0, 0, 0, 15'o123);    // j
    issue(5, 6'h00, 6'h08, 0, 0, 0, 0, 2'd2, 0, 3,  0, 0, 0, 15'o123);    // jr
    issue(6, 6'h0D, 6'h3F, 2, 0, 0, 0, 2'd0, 1, 6,  0, 0, 0, 15'o1235);   // ori, 2 fetch waits
    issue(7, 6'h00, 6'h2A, 4, 0, 0, 0, 2'd0, 1, 8,  0, 0, 0, 15'o1235);   // slt, ready at limit
    issue(8, 6'h23, 6'h00, 0, 4, 1, 0, 2'd0, 1, 9,  5, 0, 0, 15'o12345);  // lw, run dropped
    chk("run_drop_idle", 64'(state), 64'(ST_IDLE));
    chk("run_drop_count", 64'(instr_count), 64'(m_cnt));
    wait_cycles(3);
    chk("run_drop_stays_idle", 64'(state), 64'(ST_IDLE));

    // Illegal opcode traps after DECODE and freezes.
    run = 1'b1;
    issue(9, 6'h3F, 6'h00, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 15'o127);
    wait_cycles(4);
    chk("trap_hold_state", 64'(state), 64'(ST_TRAP));
    chk("trap_hold_count", 64'(instr_count), 64'd8);
    chk("trap_hold_busy", 64'(busy), 64'd0);
    do_reset();
    chk("post_trap_state", 64'(state), 64'(ST_IDLE));
    chk("post_trap_flag", 64'(trap), 64'd0);
    chk("post_trap_count", 64'(instr_count), 64'd0);

    // R-type with a funct outside the legal set.
    run = 1'b1;
    issue(10, 6'h00, 6'h21, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 15'o127);
    do_reset();

    // Fetch never answered: timeout.
    run = 1'b1;
    issue(11, 6'h00, 6'h20, 99, 0, 0, 1, 2'd0, 0, 0, 0, 0, 1, 15'o17);
    wait_cycles(2);
    chk("timeout_imem_req_dropped", 64'(mem_bus.imem_req), 64'd0);
    chk("timeout_trap", 64'(trap), 64'd1);
    do_reset();
    chk("post_timeout_bus_err", 64'(bus_err), 64'd0);

    // Store never acknowledged: timeout in MEM.
    run = 1'b1;
    issue(12, 6'h2B, 6'h00, 0, 99, 0, 1, 2'd0, 0, 0, 0, 0, 1, 15'o12347);
    do_reset();

    // Reset in the middle of a fetch handshake.
    run = 1'b1;
    opcode = 6'h00;
    funct  = 6'h20;
    wait_cycles(3);
    chk("mid_fetch_state", 64'(state), 64'(ST_FETCH));
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_fetch_reset_state", 64'(state), 64'(ST_IDLE));
    chk("mid_fetch_reset_req", 64'(mem_bus.imem_req), 64'd0);
    wait_cycles(2);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
